cache_2way_wt: RTL and testbench
================================

Name: cache_2way_wt

Overview:
- 2-way set-associative, write-through, write-allocate data cache with an internal backing main memory.
- Serves one read or write access per enabled clock.
- Reports hit/miss and returns the whole 128-bit block containing the addressed word.
- Used as the memory-side block of the processor datapath and as a standalone cache-policy test vehicle.

Parameters:
- ADDR_W, 10, byte-address width. Only 10 is supported; geometry below is derived from it.

Ports:
- clk  input  1  system clock; all state updates on rising edge
- rst_n  input  1  asynchronous active-low reset
- en  input  1  access request; 0 = idle cycle, all state and outputs hold
- read_write  input  1  0 = read, 1 = write
- address  input  10  byte address
- write_data  input  32  store word (used when read_write=1)
- read_data  output  128  registered copy of the accessed block after the access completes
- hit  output  1  registered: 1 if the access hit, 0 if it missed

Behaviour:
- Geometry:
  - 16-byte blocks (4 x 32-bit words); 2 sets x 2 ways = 4 block frames.
  - address[1:0] is the byte offset (ignored; word accesses only).
  - address[3:2] is the word offset; address[4] is the set index; address[9:5] is the 5-bit tag.
- Main memory: internal, 256 x 32-bit words, word index = address[9:2]. A block fetch reads words {address[9:4],2'b00}..{address[9:4],2'b11}. Block word w occupies bits [32w+31:32w].
- Per frame state: valid bit, 5-bit tag, 128-bit data.
- Per set state: one LRU bit naming the way to replace next.
- Reset (async, rst_n=0): all valid bits=0, all LRU bits=0, all main-memory words=0, hit=0, read_data=0.
- Access latency: single-cycle. An access presented with en=1 is fully completed at that rising edge. Lookup, fill, memory write, LRU update, and output registers all happen at that edge. hit/read_data are valid after the edge and hold until the next enabled edge.
- Lookup: hit when a valid way in set address[4] has tag == address[9:5]. If both ways match (must not occur), way 0 wins.
- Read hit: hit=1, read_data = that way's block.
- Read miss:
  - Choose a victim: an invalid way if any (way 0 preferred), else the way named by LRU.
  - Fill the victim with the block from main memory, set valid and tag.
  - hit=0, read_data = fetched block.
- Write hit:
  - Update word address[3:2] of the hitting way with write_data.
  - Write write_data to main memory at address[9:2] (write-through).
  - hit=1, read_data = updated block.
- Write miss:
  - Allocate: fetch block into the victim as for a read miss, merge write_data into word address[3:2], write main memory.
  - hit=0, read_data = merged block.
- LRU: after every enabled access (hit or miss), the set's LRU bit = the way NOT just accessed/filled.
- No dirty bits; evictions never write back (memory is always current).
- en=0: no state change; outputs hold.
- Reset asserted mid-operation: clears immediately regardless of clk. The access in that cycle is lost.

Test Plan:
- Reset then read 0x000 -> hit=0, read_data=128'h0, set0 way0 valid tag 00000, LRU[0]=1.
- Write 0x000 data 32'hFF -> hit=1, mem word 0 = 32'hFF, read_data[31:0]=32'hFF; then read 0x000 -> hit=1, read_data=128'h000..0FF.
- Read 0x200 (tag 10000, set 0) -> hit=0, fills way1; then read 0x000 -> hit=1 (both blocks coexist), LRU[0]=1.
- Read 0x300 -> hit=0, evicts way1 (0x200 block); then read 0x200 -> hit=0, evicts way0 (0x000 block), LRU[0]=1.
- Write miss to 0x01C data 32'hDEADBEEF -> hit=0, set 1 allocated, read_data[127:96]=32'hDEADBEEF, mem word 7 updated; following read 0x01C -> hit=1.
- Toggle en=0 between accesses and pulse rst_n low mid-sequence -> outputs hold while idle; reset forces hit=0, read_data=0, and the next read of 0x000 misses with data 0.

Source files
------------

// File: rtl/cache_2way_wt.sv
// cache_2way_wt: 2-way set-associative write-through write-allocate cache with internal main memory
module cache_2way_wt #(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              read_write,
    input  logic [ADDR_W-1:0] address,
    input  logic [31:0]       write_data,
    output logic [127:0]      read_data,
    output logic              hit
);
    logic [31:0]  mem [256];
    logic [3:0]   valid;
    logic [4:0]   tags [4];
    logic [127:0] blocks [4];
    logic [1:0]   lru;
    logic         set;
    logic [4:0]   tag_in;
    logic [1:0]   word;
    logic         h0, h1, hit_c, victim, way;
    logic [1:0]   idx;
    logic [127:0] fetched, base, blk;

    assign set    = address[4];
    assign tag_in = address[9:5];
    assign word   = address[3:2];
    assign h0     = valid[{set, 1'b0}] && tags[{set, 1'b0}] == tag_in;
    assign h1     = valid[{set, 1'b1}] && tags[{set, 1'b1}] == tag_in;
    assign hit_c  = h0 | h1;
    assign victim = !valid[{set, 1'b0}] ? 1'b0 : !valid[{set, 1'b1}] ? 1'b1 : lru[set];
    assign way    = h0 ? 1'b0 : h1 ? 1'b1 : victim;
    assign idx    = {set, way};
    assign base   = hit_c ? blocks[idx] : fetched;

    // Gather the four memory words of the addressed block and merge a store word into it
    always_comb begin
        fetched = '0;
        blk     = '0;
        for (int w = 0; w < 4; w++) begin
            fetched[32*w +: 32] = mem[{address[9:4], 2'(w)}];
            blk[32*w +: 32]     = (read_write && word == 2'(w)) ? write_data : base[32*w +: 32];
        end
    end

    // Complete the whole access at the clock edge: frame fill/update, write-through, LRU, outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 256; i++) mem[i] <= '0;
            for (int i = 0; i < 4; i++) begin
                tags[i]   <= '0;
                blocks[i] <= '0;
            end
            valid     <= '0;
            lru       <= '0;
            hit       <= 1'b0;
            read_data <= '0;
        end else if (en) begin
            valid[idx]  <= 1'b1;
            tags[idx]   <= tag_in;
            blocks[idx] <= blk;
            lru[set]    <= ~way;
            if (read_write) mem[address[9:2]] <= write_data;
            hit       <= hit_c;
            read_data <= blk;
        end
    end
endmodule

// File: tb/tb_cache_2way_wt.sv
// tb_cache_2way_wt: random and directed accesses checked against a behavioural cache model
module tb_cache_2way_wt;
    logic         clk, rst_n, en, read_write;
    logic [9:0]   address;
    logic [31:0]  write_data;
    logic [127:0] read_data;
    logic         hit;
    int vectors = 0;
    int miscompares = 0;

    cache_2way_wt dut (
        .clk(clk), .rst_n(rst_n), .en(en), .read_write(read_write),
        .address(address), .write_data(write_data), .read_data(read_data), .hit(hit)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    // Behavioural model: a tiny table of (valid, tag, words) per set/way plus a flat word memory
    logic [31:0]  m_mem [256];
    logic         m_valid [2][2];
    logic [4:0]   m_tag [2][2];
    logic [31:0]  m_word [2][2][4];
    int           m_next [2];
    logic         exp_hit;
    logic [127:0] exp_rd;

    task automatic model_reset();
        for (int i = 0; i < 256; i++) m_mem[i] = 0;
        for (int s = 0; s < 2; s++) begin
            m_next[s] = 0;
            for (int w = 0; w < 2; w++) m_valid[s][w] = 0;
        end
        exp_hit = 0;
        exp_rd  = 0;
    endtask

    task automatic model_access(input logic rw, input logic [9:0] a, input logic [31:0] d);
        int s, t, wo, base, w;
        s = a / 16 % 2;
        t = a / 32;
        wo = a / 4 % 4;
        base = a / 16 * 4;
        w = -1;
        for (int k = 1; k >= 0; k--) if (m_valid[s][k] && m_tag[s][k] == 5'(t)) w = k;
        exp_hit = (w >= 0);
        if (w < 0) begin
            if (!m_valid[s][0]) w = 0;
            else if (!m_valid[s][1]) w = 1;
            else w = m_next[s];
            for (int k = 0; k < 4; k++) m_word[s][w][k] = m_mem[base + k];
            m_valid[s][w] = 1;
            m_tag[s][w] = 5'(t);
        end
        if (rw) begin
            m_word[s][w][wo] = d;
            m_mem[a / 4] = d;
        end
        m_next[s] = 1 - w;
        for (int k = 0; k < 4; k++) exp_rd[32*k +: 32] = m_word[s][w][k];
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) model_reset();
        else if (en) model_access(read_write, address, write_data);
    end

    // Every cycle out of reset the registered outputs must match the model
    always @(negedge clk) begin
        if (rst_n) begin
            vectors++;
            if (hit !== exp_hit || read_data !== exp_rd) begin
                miscompares++;
                $display("FAIL model_cmp hit=%0b rd=%h required hit=%0b rd=%h", hit, read_data, exp_hit, exp_rd);
            end
        end
    end

    task automatic access(input logic rw, input logic [9:0] a, input logic [31:0] d);
        en = 1; read_write = rw; address = a; write_data = d;
        @(posedge clk); #1;
        en = 0;
    endtask

    task automatic lit(input string name, input logic h, input logic [127:0] rd);
        @(negedge clk);
        vectors++;
        if (hit !== h || read_data !== rd) begin
            miscompares++;
            $display("FAIL %s hit=%0b rd=%h required hit=%0b rd=%h", name, hit, read_data, h, rd);
        end
    endtask

    initial begin
        rst_n = 0; en = 0; read_write = 0; address = 0; write_data = 0;
        #12 rst_n = 1;
        @(posedge clk); #1;
        lit("reset", 0, 0);
        access(0, 10'h000, 0);          lit("rd0_miss", 0, 0);
        access(1, 10'h000, 32'hFF);     lit("wr0_hit", 1, 128'hFF);
        access(0, 10'h000, 0);          lit("rd0_hit", 1, 128'hFF);
        access(0, 10'h200, 0);          lit("rd200_miss", 0, 0);
        access(0, 10'h000, 0);          lit("rd0_coexist", 1, 128'hFF);
        access(0, 10'h300, 0);          lit("rd300_evict1", 0, 0);
        access(0, 10'h200, 0);          lit("rd200_evict0", 0, 0);
        access(0, 10'h000, 0);          lit("rd0_refetch", 0, 128'hFF);
        access(1, 10'h01C, 32'hDEADBEEF);
        lit("wr1c_alloc", 0, {32'hDEADBEEF, 96'h0});
        repeat (3) @(posedge clk);
        #1 lit("idle_hold", 0, {32'hDEADBEEF, 96'h0});
        access(0, 10'h01C, 0);          lit("rd1c_hit", 1, {32'hDEADBEEF, 96'h0});
        access(0, 10'h010, 0);          lit("rd10_hit_word3", 1, {32'hDEADBEEF, 96'h0});
        @(posedge clk); #3 rst_n = 0; #4 rst_n = 1;
        lit("mid_reset", 0, 0);
        access(0, 10'h000, 0);          lit("post_reset_rd0", 0, 0);
        access(0, 10'h01C, 0);          lit("post_reset_rd1c", 0, 0);
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 7) == 0) begin
                @(posedge clk); #1;
            end else begin
                access(1'($urandom_range(0, 1)),
                       {5'($urandom_range(0, 3)), 5'($urandom_range(0, 31))},
                       $urandom);
            end
            if (i == 300) begin
                #2 rst_n = 0; #2 rst_n = 1;
            end
        end
        @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
